jt900h_busarb: RTL and testbench
================================

# jt900h_busarb

Memory bus arbiter and sequencer for the JT900H core. It shares the single 16-bit RAM port between two requesters: the instruction-fetch buffer and the data load/store path. Each granted access is split into 16-bit beats, handling odd addresses and lengths of 1, 2 or 4 bytes. Read bytes are assembled into a little-endian 32-bit word, and one ack pulse is returned per transaction. It sits between the controller/PC logic and the external RAM interface.

## Interface
- No parameters; all widths are fixed by the RAM interface.
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- cen  in  1  clock enable; all state advances only when high
- if_req  in  1  fetch request; held until if_ack
- if_addr  in  24  fetch byte address; fetch length is fixed at 4 bytes
- if_ack  out  1  one-cycle pulse; if_data valid in the same cycle
- if_data  out  32  fetched bytes, little-endian, byte at if_addr in [7:0]
- dt_req  in  1  data request; held until dt_ack
- dt_we  in  1  1 = store, 0 = load
- dt_len  in  3  one-hot length: 001 = byte, 010 = word, 100 = long
- dt_addr  in  24  data byte address
- dt_wdata  in  32  store data, little-endian
- dt_ack  out  1  one-cycle pulse completing a data transaction
- dt_rdata  out  32  load data, zero-extended for byte and word
- ram_addr  out  24  beat address, always even
- ram_din  out  16  write data to RAM
- ram_dout  in  16  read data; valid one cen cycle after ram_addr
- ram_we  out  2  byte write enables: [0] = even byte, [1] = odd byte
- busy  out  1  high whenever state is not IDLE

## Operation
- **States**
  - IDLE: a request may be granted.
  - ISSUE: one beat per cen cycle.
  - DONE: ack cycle; no new grant is made here.
- **Arbitration**
  - At an IDLE edge, if dt_req is high, the data requester is granted.
  - Otherwise, if if_req is high, the fetch requester is granted.
  - Data has fixed priority. A granted transaction always completes and is never pre-empted.
- **Grant latch**
  - At grant, the block latches addr, len, we and wdata.
  - Requester inputs are ignored after that until IDLE.
- **Length decode**
  - dt_len[2] set gives 4 bytes; otherwise dt_len[1] set gives 2 bytes; otherwise 1 byte.
- **Beat count**
  - k = ceil((addr[0] + bytes) / 2), so k is 1, 2 or 3.
  - Beat n uses address {addr[23:1],1'b0} + 2n, modulo 2^24 (FFFFFE wraps to 000000).
- **Reads**
  - Byte i of the result is taken from beat floor((addr[0]+i)/2), lane (addr[0]+i)&1.
  - Unused result bytes are 0.
- **Writes**
  - ram_we enables exactly the lanes that hold bytes of the transaction.
  - ram_din carries those bytes in their lanes; unused lanes drive 0.
- **Fetch** uses the same path with bytes = 4 and we = 0.
- **Ack and data hold**
  - The ack of the granted requester pulses in DONE.
  - if_data and dt_rdata hold their value until the next read by the same requester completes.

## Timing
- Edge E0 is the IDLE grant edge.
- ram_addr and ram_we for beat n are registered at edge E(n) and visible in cycle n+1.
- Read capture of beat n happens at edge E(n+1).
- At E(k), state goes to DONE, ack is set, and ram_we returns to 0.
- Ack is high in cycle k+1; state is back in IDLE at cycle k+2.
- Grant to ack is k+1 cen cycles; back-to-back transactions have a one-cycle DONE bubble.
- With cen low, all registers hold, ack included; an ack lasts exactly one cen-qualified cycle.
- Reset (async, mid-operation too) forces the following values and abandons any transaction with no ack:
  - state = IDLE
  - ram_addr = 0, ram_din = 0, ram_we = 0
  - if_ack = 0, dt_ack = 0
  - if_data = 0, dt_rdata = 0
  - busy = 0
- If both requests rise in the same cycle, data is served first and the fetch is granted at the IDLE edge after data's DONE.

## Structure
- Shared jt900h_pkg holds:
  - length encodings LEN_BYTE = 3'b001, LEN_WORD = 3'b010, LEN_LONG = 3'b100
  - the arbiter state enum: IDLE, ISSUE, DONE
- One sub-module, jt900h_bytesteer, is natural. It is combinational lane steering that computes, from addr[0], len and beat index:
  - ram_we
  - ram_din lanes
  - read-byte placement
- The FSM, beat counter and grant latch stay in jt900h_busarb.

## Test plan
- **Aligned long load:** dt load, len 100, addr 000100; RAM holds 000100 = 2211 and 000102 = 4433 → beats at 000100 and 000102, dt_rdata = 44332211, dt_ack in cycle 3.
- **Odd long load:** addr 000101; RAM holds 000100 = 2211, 000102 = 4433, 000104 = 6655 → beats 000100/000102/000104, dt_rdata = 55443322, ack in cycle 4.
- **Odd word store:** len 010, addr 000203, wdata 0000BBAA → beat 000202 with ram_we = 10, ram_din = AA00; then beat 000204 with ram_we = 01, ram_din = 00BB; ack in cycle 3.
- **Simultaneous requests:** if_req and dt_req rise together → dt_ack first; fetch beats start only after DONE; if_ack follows; no beat is lost or duplicated.
- **Wrap-around:** fetch at FFFFFF → beats FFFFFE, 000000, 000002; if_data holds the bytes from FFFFFF, 000000, 000001, 000002, packed [7:0] to [31:24].
- **Reset and cen:**
  - rst low during beat 2 of a 3-beat store → ram_we = 0 immediately, no ack, IDLE after release.
  - cen toggled at 50% → identical beat sequence, with latency counted in cen cycles.

Source files
------------

// File: rtl/jt900h_busarb_pkg.sv
// Shared definitions for the JT900H bus arbiter: length encodings, arbiter states
// and the length/beat-count helpers used by the arbiter and its lane steering.
package jt900h_pkg;

  localparam logic [2:0] LEN_BYTE = 3'b001;
  localparam logic [2:0] LEN_WORD = 3'b010;
  localparam logic [2:0] LEN_LONG = 3'b100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // The highest set bit of the one-hot length wins, so malformed codes still decode.
  function automatic logic [2:0] len_bytes(input logic [2:0] len);
    return len[2] ? 3'd4 : (len[1] ? 3'd2 : 3'd1);
  endfunction

  function automatic logic [1:0] beat_count(input logic odd, input logic [2:0] len);
    logic [2:0] sum;
    sum = len_bytes(len) + {2'b00, odd} + 3'd1;
    return 2'(sum >> 1);
  endfunction

endpackage

// File: rtl/jt900h_busarb_if.sv
// Request/ack and RAM-port signals of the JT900H bus arbiter; the arbiter uses the
// slave view, the requesters plus RAM model use the master view.
interface jt900h_busarb_if;

  logic        if_req;
  logic [23:0] if_addr;
  logic        if_ack;
  logic [31:0] if_data;
  logic        dt_req;
  logic        dt_we;
  logic [2:0]  dt_len;
  logic [23:0] dt_addr;
  logic [31:0] dt_wdata;
  logic        dt_ack;
  logic [31:0] dt_rdata;
  logic [23:0] ram_addr;
  logic [15:0] ram_din;
  logic [15:0] ram_dout;
  logic [1:0]  ram_we;
  logic        busy;

  modport slave (
    input  if_req, if_addr, dt_req, dt_we, dt_len, dt_addr, dt_wdata, ram_dout,
    output if_ack, if_data, dt_ack, dt_rdata, ram_addr, ram_din, ram_we, busy
  );

  modport master (
    output if_req, if_addr, dt_req, dt_we, dt_len, dt_addr, dt_wdata, ram_dout,
    input  if_ack, if_data, dt_ack, dt_rdata, ram_addr, ram_din, ram_we, busy
  );

endinterface

// File: rtl/jt900h_busarb_bytesteer.sv
// Combinational lane steering: maps transaction bytes onto the two RAM lanes of a
// beat for writes, and places the lanes of a read beat into the 32-bit result.
module jt900h_bytesteer
  import jt900h_pkg::*;
(
  input  logic        i_odd,
  input  logic [2:0]  i_len,
  input  logic [1:0]  i_wbeat,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_rbeat,
  input  logic [15:0] i_rdata,
  output logic [1:0]  o_we,
  output logic [15:0] o_din,
  output logic [31:0] o_rplace
);

  logic [2:0] w_nb;
  logic [3:0] w_wpos;
  logic       w_whit;
  logic [2:0] w_rsum;
  logic       w_rhit;

  // Byte p of the transaction sits at lane (odd+p)&1 of beat (odd+p)>>1.
  always_comb begin
    w_nb     = len_bytes(i_len);
    o_we     = 2'b00;
    o_din    = 16'h0000;
    o_rplace = 32'h0000_0000;
    w_wpos   = 4'd0;
    w_whit   = 1'b0;
    w_rsum   = 3'd0;
    w_rhit   = 1'b0;
    for (int l = 0; l < 2; l++) begin
      // Lane 0 of beat 0 on an odd address yields 4'hF, which is never a valid byte.
      w_wpos   = {1'b0, i_wbeat, 1'b0} + 4'(l) - {3'b000, i_odd};
      w_whit   = (w_wpos < {1'b0, w_nb});
      o_we[l]  = w_whit;
      o_din[8*l +: 8] = w_whit ? i_wdata[{w_wpos[1:0], 3'b000} +: 8] : 8'h00;
    end
    for (int i = 0; i < 4; i++) begin
      w_rsum = 3'(i) + {2'b00, i_odd};
      w_rhit = (w_rsum[2:1] == i_rbeat) && (3'(i) < w_nb);
      o_rplace[8*i +: 8] = w_rhit ? i_rdata[{w_rsum[0], 3'b000} +: 8] : 8'h00;
    end
  end

endmodule

// File: rtl/jt900h_busarb.sv
// JT900H memory bus arbiter: grants the shared 16-bit RAM port to the data path
// (fixed priority) or the fetch buffer and sequences each access as 1-3 beats.
module jt900h_busarb
  import jt900h_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           cen,
  jt900h_busarb_if.slave bus
);

  state_t      r_state;
  logic        r_dt, r_we, r_odd, r_busy, r_if_ack, r_dt_ack;
  logic [22:0] r_base;
  logic [2:0]  r_len;
  logic [1:0]  r_beat, r_ram_we;
  logic [31:0] r_wdata, r_rbuf, r_if_data, r_dt_rdata;
  logic [23:0] r_ram_addr;
  logic [15:0] r_ram_din;

  logic        w_idle, w_gnt, w_gnt_we, w_odd, w_we;
  logic [23:0] w_gnt_addr, w_beat_addr;
  logic [2:0]  w_gnt_len, w_len;
  logic [31:0] w_gnt_wdata, w_wdata, w_rplace, w_rword;
  logic [22:0] w_base;
  logic [1:0]  w_wbeat, w_rbeat, w_k, w_st_we, w_beat_we;
  logic [15:0] w_st_din, w_beat_din;

  // In IDLE the steering sees the incoming request so beat 0 issues on the grant edge.
  always_comb begin
    w_idle = (r_state == IDLE);
    w_gnt  = bus.dt_req | bus.if_req;
    if (bus.dt_req) begin
      w_gnt_addr  = bus.dt_addr;
      w_gnt_len   = bus.dt_len;
      w_gnt_we    = bus.dt_we;
      w_gnt_wdata = bus.dt_wdata;
    end else begin
      w_gnt_addr  = bus.if_addr;
      w_gnt_len   = LEN_LONG;
      w_gnt_we    = 1'b0;
      w_gnt_wdata = 32'h0000_0000;
    end
    if (w_idle) begin
      w_odd   = w_gnt_addr[0];
      w_base  = w_gnt_addr[23:1];
      w_len   = w_gnt_len;
      w_we    = w_gnt_we;
      w_wdata = w_gnt_wdata;
      w_wbeat = 2'd0;
    end else begin
      w_odd   = r_odd;
      w_base  = r_base;
      w_len   = r_len;
      w_we    = r_we;
      w_wdata = r_wdata;
      w_wbeat = r_beat;
    end
    w_rbeat = r_beat - 2'd1;
  end

  jt900h_bytesteer u_steer (
    .i_odd    (w_odd),
    .i_len    (w_len),
    .i_wbeat  (w_wbeat),
    .i_wdata  (w_wdata),
    .i_rbeat  (w_rbeat),
    .i_rdata  (bus.ram_dout),
    .o_we     (w_st_we),
    .o_din    (w_st_din),
    .o_rplace (w_rplace)
  );

  // Next-beat RAM values and the read word completed by the beat now being captured.
  always_comb begin
    w_beat_addr = {w_base, 1'b0} + {21'd0, w_wbeat, 1'b0};
    w_beat_we   = w_we ? w_st_we : 2'b00;
    w_beat_din  = w_we ? w_st_din : 16'h0000;
    w_rword     = r_rbuf | w_rplace;
    w_k         = beat_count(r_odd, r_len);
  end

  // Arbiter FSM: grant latch, beat issue/capture and registered acks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_dt       <= 1'b0;
      r_we       <= 1'b0;
      r_odd      <= 1'b0;
      r_busy     <= 1'b0;
      r_if_ack   <= 1'b0;
      r_dt_ack   <= 1'b0;
      r_base     <= 23'd0;
      r_len      <= 3'b000;
      r_beat     <= 2'd0;
      r_ram_we   <= 2'b00;
      r_wdata    <= 32'h0000_0000;
      r_rbuf     <= 32'h0000_0000;
      r_if_data  <= 32'h0000_0000;
      r_dt_rdata <= 32'h0000_0000;
      r_ram_addr <= 24'h00_0000;
      r_ram_din  <= 16'h0000;
    end else if (cen) begin
      r_if_ack <= 1'b0;
      r_dt_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_gnt) begin
            r_dt       <= bus.dt_req;
            r_we       <= w_gnt_we;
            r_odd      <= w_gnt_addr[0];
            r_base     <= w_gnt_addr[23:1];
            r_len      <= w_gnt_len;
            r_wdata    <= w_gnt_wdata;
            r_rbuf     <= 32'h0000_0000;
            r_beat     <= 2'd1;
            r_ram_addr <= w_beat_addr;
            r_ram_we   <= w_beat_we;
            r_ram_din  <= w_beat_din;
            r_busy     <= 1'b1;
            r_state    <= ISSUE;
          end else begin
            r_busy <= 1'b0;
          end
        end
        ISSUE: begin
          r_rbuf <= w_rword;
          if (r_beat == w_k) begin
            r_ram_we  <= 2'b00;
            r_ram_din <= 16'h0000;
            r_state   <= DONE;
            if (r_dt) begin
              r_dt_ack <= 1'b1;
              if (!r_we) begin
                r_dt_rdata <= w_rword;
              end
            end else begin
              r_if_ack  <= 1'b1;
              r_if_data <= w_rword;
            end
          end else begin
            r_ram_addr <= w_beat_addr;
            r_ram_we   <= w_beat_we;
            r_ram_din  <= w_beat_din;
            r_beat     <= r_beat + 2'd1;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy   <= 1'b0;
          r_ram_we <= 2'b00;
          r_state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.ram_addr = r_ram_addr;
  assign bus.ram_din  = r_ram_din;
  assign bus.ram_we   = r_ram_we;
  assign bus.if_ack   = r_if_ack;
  assign bus.if_data  = r_if_data;
  assign bus.dt_ack   = r_dt_ack;
  assign bus.dt_rdata = r_dt_rdata;
  assign bus.busy     = r_busy;

endmodule

// File: tb/tb_jt900h_busarb.sv
// Directed bench for jt900h_busarb: a table of single transactions with hand-computed
// beats and results, then sequences for simultaneous requests, mid-beat reset and cen.
module tb_jt900h_busarb;
  import jt900h_pkg::*;

  typedef struct {
    logic             fetch;
    logic             we;
    logic [2:0]       len;
    logic [23:0]      addr;
    logic [31:0]      wdata;
    logic [1:0]       k;
    logic [2:0][23:0] b_addr;
    logic [2:0][1:0]  b_we;
    logic [2:0][15:0] b_din;
    logic [31:0]      exp_data;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic cen;
  logic cen_mode = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;
  vec_t vecs[13];
  vec_t tmp;

  jt900h_busarb_if bus();

  jt900h_busarb dut (
    .clk (clk),
    .rst (rst),
    .cen (cen),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    cen = 1'b1;
    forever begin
      @(negedge clk);
      cen = cen_mode ? ~cen : 1'b1;
    end
  end

  function automatic logic [15:0] ram_word(input logic [23:0] a);
    case (a)
      24'h000100: ram_word = 16'h2211;
      24'h000102: ram_word = 16'h4433;
      24'h000104: ram_word = 16'h6655;
      24'hFFFFFE: ram_word = 16'h1E0F;
      24'h000000: ram_word = 16'h2B1A;
      24'h000002: ram_word = 16'h4D3C;
      default:    ram_word = {~a[7:0], a[7:0]};
    endcase
  endfunction

  always_comb bus.ram_dout = ram_word(bus.ram_addr);

  function automatic vec_t mk(input logic f, input logic w, input logic [2:0] l,
                              input logic [23:0] a, input logic [31:0] wd, input logic [1:0] k,
                              input logic [23:0] a0, input logic [23:0] a1, input logic [23:0] a2,
                              input logic [1:0] e0, input logic [1:0] e1, input logic [1:0] e2,
                              input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2,
                              input logic [31:0] ex);
    vec_t v;
    v.fetch = f; v.we = w; v.len = l; v.addr = a; v.wdata = wd; v.k = k;
    v.b_addr[0] = a0; v.b_addr[1] = a1; v.b_addr[2] = a2;
    v.b_we[0] = e0; v.b_we[1] = e1; v.b_we[2] = e2;
    v.b_din[0] = d0; v.b_din[1] = d1; v.b_din[2] = d2;
    v.exp_data = ex;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Advance to just after the next clock edge at which cen is high.
  task automatic tick();
    int  n;
    bit  got;
    n   = 0;
    got = 1'b0;
    while (!got && n < 16) begin
      @(posedge clk);
      got = cen;
      n++;
    end
    #1;
    if (!got) begin
      n_vec++;
      n_bad++;
      $display("FAIL tick: no cen-qualified edge within 16 clocks");
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    if (v.fetch) begin
      bus.if_req  = 1'b1;
      bus.if_addr = v.addr;
    end else begin
      bus.dt_req   = 1'b1;
      bus.dt_we    = v.we;
      bus.dt_len   = v.len;
      bus.dt_addr  = v.addr;
      bus.dt_wdata = v.wdata;
    end
    tick();
    for (int c = 0; c < int'(v.k); c++) begin
      chk({tag, " ram_addr"}, {8'h00, bus.ram_addr}, {8'h00, v.b_addr[c]});
      chk({tag, " ram_we"}, {30'd0, bus.ram_we}, {30'd0, v.b_we[c]});
      chk({tag, " ram_din"}, {16'h0000, bus.ram_din}, {16'h0000, v.b_din[c]});
      chk({tag, " beat acks/busy"}, {29'd0, bus.if_ack, bus.dt_ack, bus.busy}, 32'd1);
      tick();
    end
    chk({tag, " ack"}, {30'd0, bus.if_ack, bus.dt_ack}, v.fetch ? 32'd2 : 32'd1);
    chk({tag, " data"}, v.fetch ? bus.if_data : bus.dt_rdata, v.exp_data);
    chk({tag, " done ram_we"}, {30'd0, bus.ram_we}, 32'd0);
    bus.if_req = 1'b0;
    bus.dt_req = 1'b0;
    if (cen_mode) begin
      @(posedge clk);
      #1;
      chk({tag, " ack held cen low"}, {30'd0, bus.if_ack, bus.dt_ack}, v.fetch ? 32'd2 : 32'd1);
    end
    tick();
    chk({tag, " idle acks/busy"}, {29'd0, bus.if_ack, bus.dt_ack, bus.busy}, 32'd0);
  endtask

  initial begin
    vecs[0]  = mk(1'b0, 1'b0, LEN_LONG, 24'h000100, 32'h0, 2'd2, 24'h000100, 24'h000102, 24'h0,
                  2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 32'h44332211);
    vecs[1]  = mk(1'b0, 1'b0, LEN_LONG, 24'h000101, 32'h0, 2'd3, 24'h000100, 24'h000102, 24'h000104,
                  2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 32'h55443322);
    vecs[2]  = mk(1'b0, 1'b1, LEN_WORD, 24'h000203, 32'h0000BBAA, 2'd2, 24'h000202, 24'h000204, 24'h0,
                  2'b10, 2'b01, 2'b00, 16'hAA00, 16'h00BB, 16'h0, 32'h55443322);
    vecs[3]  = mk(1'b0, 1'b0, LEN_BYTE, 24'h000101, 32'h0, 2'd1, 24'h000100, 24'h0, 24'h0,
                  2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 32'h00000022);
    vecs[4]  = mk(1'b0, 1'b0, LEN_WORD, 24'h000102, 32'h0, 2'd1, 24'h000102, 24'h0, 24'h0,
                  2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 32'h00004433);
    vecs[5]  = mk(1'b0, 1'b0, LEN_WORD, 24'h000103, 32'h0, 2'd2, 24'h000102, 24'h000104, 24'h0,
                  2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 32'h00005544);
    vecs[6]  = mk(1'b0, 1'b1, LEN_LONG, 24'h000300, 32'h87654321, 2'd2, 24'h000300, 24'h000302, 24'h0,
                  2'b11, 2'b11, 2'b00, 16'h4321, 16'h8765, 16'h0, 32'h00005544);
    vecs[7]  = mk(1'b0, 1'b1, LEN_BYTE, 24'h000301, 32'h12345678, 2'd1, 24'h000300, 24'h0, 24'h0,
                  2'b10, 2'b00, 2'b00, 16'h7800, 16'h0, 16'h0, 32'h00005544);
    vecs[8]  = mk(1'b0, 1'b1, LEN_BYTE, 24'h000300, 32'h12345678, 2'd1, 24'h000300, 24'h0, 24'h0,
                  2'b01, 2'b00, 2'b00, 16'h0078, 16'h0, 16'h0, 32'h00005544);
    vecs[9]  = mk(1'b1, 1'b0, LEN_LONG, 24'h000100, 32'h0, 2'd2, 24'h000100, 24'h000102, 24'h0,
                  2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 32'h44332211);
    vecs[10] = mk(1'b1, 1'b0, LEN_LONG, 24'hFFFFFF, 32'h0, 2'd3, 24'hFFFFFE, 24'h000000, 24'h000002,
                  2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 32'h3C2B1A1E);
    vecs[11] = mk(1'b0, 1'b1, LEN_LONG, 24'h000401, 32'hDDCCBBAA, 2'd3, 24'h000400, 24'h000402, 24'h000404,
                  2'b10, 2'b11, 2'b01, 16'hAA00, 16'hCCBB, 16'h00DD, 32'h00005544);
    vecs[12] = mk(1'b0, 1'b0, 3'b011, 24'h000100, 32'h0, 2'd1, 24'h000100, 24'h0, 24'h0,
                  2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 32'h00002211);

    rst = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = 24'h0;
    bus.dt_req = 1'b0; bus.dt_we = 1'b0; bus.dt_len = LEN_BYTE;
    bus.dt_addr = 24'h0; bus.dt_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ram_addr/din", {bus.ram_addr, 8'h00}, 32'h0);
    chk("reset ram_din", {16'h0000, bus.ram_din}, 32'h0);
    chk("reset we/acks/busy", {27'd0, bus.ram_we, bus.if_ack, bus.dt_ack, bus.busy}, 32'd0);
    chk("reset if_data", bus.if_data, 32'h0);
    chk("reset dt_rdata", bus.dt_rdata, 32'h0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 13; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Both requests together: data first, one bubble cycle, then the fetch.
    bus.dt_req = 1'b1; bus.dt_we = 1'b0; bus.dt_len = LEN_BYTE; bus.dt_addr = 24'h000104;
    bus.if_req = 1'b1; bus.if_addr = 24'h000102;
    tick();
    chk("sim dt beat", {8'h00, bus.ram_addr}, 32'h000104);
    tick();
    chk("sim dt ack", {30'd0, bus.if_ack, bus.dt_ack}, 32'd1);
    chk("sim dt data", bus.dt_rdata, 32'h00000055);
    bus.dt_req = 1'b0;
    tick();
    chk("sim bubble", {29'd0, bus.if_ack, bus.dt_ack, bus.busy}, 32'd0);
    tick();
    chk("sim if beat0", {8'h00, bus.ram_addr}, 32'h000102);
    chk("sim if busy", {31'd0, bus.busy}, 32'd1);
    tick();
    chk("sim if beat1", {8'h00, bus.ram_addr}, 32'h000104);
    chk("sim if no ack yet", {30'd0, bus.if_ack, bus.dt_ack}, 32'd0);
    tick();
    chk("sim if ack", {30'd0, bus.if_ack, bus.dt_ack}, 32'd2);
    chk("sim if data", bus.if_data, 32'h66554433);
    chk("sim dt data held", bus.dt_rdata, 32'h00000055);
    bus.if_req = 1'b0;
    tick();
    chk("sim idle", {31'd0, bus.busy}, 32'd0);

    // Asynchronous reset during beat 2 of a 3-beat store.
    bus.dt_req = 1'b1; bus.dt_we = 1'b1; bus.dt_len = LEN_LONG;
    bus.dt_addr = 24'h000401; bus.dt_wdata = 32'hDDCCBBAA;
    tick();
    tick();
    chk("rst pre beat2 we", {30'd0, bus.ram_we}, 32'd3);
    rst = 1'b0;
    bus.dt_req = 1'b0;
    #1;
    chk("rst async we/acks/busy", {27'd0, bus.ram_we, bus.if_ack, bus.dt_ack, bus.busy}, 32'd0);
    chk("rst async ram_addr", {8'h00, bus.ram_addr}, 32'h0);
    chk("rst async dt_rdata", bus.dt_rdata, 32'h0);
    chk("rst async if_data", bus.if_data, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst no ack", {29'd0, bus.if_ack, bus.dt_ack, bus.busy}, 32'd0);
    end
    run_vec(vecs[0], "post-rst v0");

    // cen at 50%: same beats, latency counted in cen cycles, ack held while cen low.
    cen_mode = 1'b1;
    run_vec(vecs[1], "cen v1");
    tmp = vecs[11];
    tmp.exp_data = 32'h55443322;
    run_vec(tmp, "cen v11");
    run_vec(vecs[10], "cen v10");
    cen_mode = 1'b0;
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
